// File: rtl/life_gen_engine.sv
// Game-of-Life (B3/S23) generation engine on a toroidal ROWS x COLS grid.
// One row of the next generation is produced per clock; the whole grid commits in one cycle.
module life_gen_engine #(
    parameter int ROWS  = 8,
    parameter int COLS  = 8,
    parameter int GEN_W = 8,
    localparam int RW   = (ROWS > 1) ? $clog2(ROWS) : 1,
    localparam int PW   = $clog2(ROWS*COLS+1)
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 Load_En,
    input  logic [RW-1:0]        Load_Row,
    input  logic [COLS-1:0]      Load_Data,
    input  logic [GEN_W-1:0]     Gen_Target,
    input  logic                 Step_Mode,
    input  logic                 Start,
    input  logic                 Step,
    input  logic                 Ack,
    output logic [ROWS*COLS-1:0] Grid,
    output logic [GEN_W-1:0]     Gen_Count,
    output logic [PW-1:0]        Pop_Count,
    output logic                 Stable,
    output logic                 q_I,
    output logic                 q_Comp,
    output logic                 q_Pause,
    output logic                 q_Done
);

    typedef enum logic [2:0] {
        S_INIT    = 3'd0,
        S_COMPUTE = 3'd1,
        S_COMMIT  = 3'd2,
        S_PAUSE   = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t                 state_reg, state_next;
    logic [ROWS*COLS-1:0]   grid_reg;
    logic [ROWS*COLS-1:0]   next_reg;
    logic [GEN_W-1:0]       gen_count_reg;
    logic [PW-1:0]          pop_count_reg;
    logic [PW-1:0]          pop_acc_reg;
    logic                   stable_reg;
    logic [RW-1:0]          row_idx_reg;

    logic [RW-1:0]          row_up, row_dn;
    logic [COLS-1:0]        row_above, row_cur, row_below, row_new;
    logic [PW-1:0]          row_pop;
    logic [GEN_W-1:0]       gen_inc;
    logic                   last_row;
    logic                   grid_same;

    // Toroidal neighbour rows of the row currently being computed.
    always_comb begin
        row_up = (row_idx_reg == '0) ? RW'(ROWS-1) : row_idx_reg - 1'b1;
        row_dn = (row_idx_reg == RW'(ROWS-1)) ? '0 : row_idx_reg + 1'b1;
    end

    assign row_above = grid_reg[row_up*COLS +: COLS];
    assign row_cur   = grid_reg[row_idx_reg*COLS +: COLS];
    assign row_below = grid_reg[row_dn*COLS +: COLS];
    assign last_row  = (row_idx_reg == RW'(ROWS-1));
    assign gen_inc   = gen_count_reg + GEN_W'(1);
    assign grid_same = (next_reg == grid_reg);

    genvar gi;
    generate
        for (gi = 0; gi < COLS; gi++) begin : g_cell
            localparam int CL = (gi + COLS - 1) % COLS;
            localparam int CR = (gi + 1) % COLS;
            logic [3:0] nsum;
            assign nsum = 4'(row_above[CL]) + 4'(row_above[gi]) + 4'(row_above[CR])
                        + 4'(row_cur[CL])                       + 4'(row_cur[CR])
                        + 4'(row_below[CL]) + 4'(row_below[gi]) + 4'(row_below[CR]);
            assign row_new[gi] = (nsum == 4'd3) || (row_cur[gi] && (nsum == 4'd2));
        end
    endgenerate

    always_comb begin
        row_pop = '0;
        for (int c = 0; c < COLS; c++) begin
            row_pop = row_pop + PW'(row_new[c]);
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_reg <= S_INIT;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_INIT: begin
                if (Start && !Load_En) state_next = S_COMPUTE;
            end
            S_COMPUTE: begin
                if (last_row) state_next = S_COMMIT;
            end
            S_COMMIT: begin
                if (grid_same)
                    state_next = S_DONE;
                else if ((Gen_Target != '0) && (gen_inc == Gen_Target))
                    state_next = S_DONE;
                else if (Step_Mode)
                    state_next = S_PAUSE;
                else
                    state_next = S_COMPUTE;
            end
            S_PAUSE: begin
                if (Ack)       state_next = S_DONE;
                else if (Step) state_next = S_COMPUTE;
            end
            S_DONE: begin
                if (Ack) state_next = S_INIT;
            end
            default: state_next = S_INIT;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            grid_reg      <= '0;
            next_reg      <= '0;
            gen_count_reg <= '0;
            pop_count_reg <= '0;
            pop_acc_reg   <= '0;
            stable_reg    <= 1'b0;
            row_idx_reg   <= '0;
        end else begin
            case (state_reg)
                S_INIT: begin
                    // A load in the same cycle as Start wins; the Start is dropped.
                    if (Load_En) begin
                        if (int'(Load_Row) < ROWS)
                            grid_reg[Load_Row*COLS +: COLS] <= Load_Data;
                    end else if (Start) begin
                        gen_count_reg <= '0;
                        stable_reg    <= 1'b0;
                        row_idx_reg   <= '0;
                        pop_acc_reg   <= '0;
                    end
                end
                S_COMPUTE: begin
                    next_reg[row_idx_reg*COLS +: COLS] <= row_new;
                    pop_acc_reg <= pop_acc_reg + row_pop;
                    row_idx_reg <= last_row ? '0 : row_idx_reg + 1'b1;
                end
                S_COMMIT: begin
                    grid_reg      <= next_reg;
                    gen_count_reg <= gen_inc;
                    pop_count_reg <= pop_acc_reg;
                    stable_reg    <= grid_same;
                    row_idx_reg   <= '0;
                    pop_acc_reg   <= '0;
                end
                default: ;
            endcase
        end
    end

    assign Grid      = grid_reg;
    assign Gen_Count = gen_count_reg;
    assign Pop_Count = pop_count_reg;
    assign Stable    = stable_reg;
    assign q_I       = (state_reg == S_INIT);
    assign q_Comp    = (state_reg == S_COMPUTE) || (state_reg == S_COMMIT);
    assign q_Pause   = (state_reg == S_PAUSE);
    assign q_Done    = (state_reg == S_DONE);

endmodule
